// File: rtl/sqrt_seq.sv
// Sequential restoring integer square root. Produces one root bit per enabled
// clock edge and returns floor(sqrt(dt)) with the remainder dt - root^2.
module sqrt_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enb_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   dt_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [WIDTH/2-1:0] root_o,
    output logic [WIDTH/2:0]   rem_o
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [N+1:0]     rem_q, rem_d;
    logic [N-1:0]     root_q, root_d;
    logic [N-1:0]     root_o_q, root_o_d;
    logic [N:0]       rem_o_q, rem_o_d;

    logic [N+1:0]     rem_sh;
    logic [N+1:0]     trial;
    logic             fits;

    // Partial remainder never exceeds 2*root, so N+2 bits hold the shifted value exactly.
    always_comb begin
        rem_sh = (rem_q << 2) | {{N{1'b0}}, sh_q[WIDTH-1 -: 2]};
        trial  = {root_q, 2'b01};
        fits   = (rem_sh >= trial);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        rem_d    = rem_q;
        root_d   = root_q;
        root_o_d = root_o_q;
        rem_o_d  = rem_o_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sh_d    = dt_i;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                sh_d  = sh_q << 2;
                cnt_d = cnt_q - CW'(1);
                if (fits) begin
                    rem_d  = rem_sh - trial;
                    root_d = {root_q[N-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh;
                    root_d = {root_q[N-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    root_o_d = root_d;
                    rem_o_d  = rem_d[N:0];
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            root_o_q <= '0;
            rem_o_q  <= '0;
        end else if (enb_i) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            root_o_q <= root_o_d;
            rem_o_q  <= rem_o_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = (state_q == DONE);
    assign root_o  = root_o_q;
    assign rem_o   = rem_o_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// Scoreboard bench for sqrt_seq (WIDTH=16): driver pushes expected results,
// an independent monitor pops and compares on every valid_o pulse.
module tb_sqrt_seq;
    localparam int W = 16;
    localparam int N = W / 2;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         enb_i = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] dt_i = '0;
    logic         busy_o;
    logic         valid_o;
    logic [N-1:0] root_o;
    logic [N:0]   rem_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rst_edge = 1'b1;

    typedef struct {
        int unsigned dt;
        int unsigned root;
        int unsigned rem;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    sqrt_seq #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .enb_i   (enb_i),
        .start_i (start_i),
        .dt_i    (dt_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .root_o  (root_o),
        .rem_o   (rem_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: largest r with r*r <= x, found by arithmetic search.
    function automatic int unsigned isqrt(input int unsigned x);
        longint unsigned r;
        r = longint'($sqrt(real'(x)));
        while (r * r > longint'(x)) r--;
        while ((r + 1) * (r + 1) <= longint'(x)) r++;
        return int'(r);
    endfunction

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_o) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                $display("FAIL wait_idle: busy_o stuck high for %0d cycles", t);
                $fatal(1, "busy stuck");
            end
        end
    endtask

    // One computation: optional CALC stall (sa/len), optional dropped start, optional DONE stall.
    task automatic do_op(input int unsigned dt, input int sa, input int len,
                         input bit inject, input int ds);
        exp_t e;
        wait_idle();
        start_i = 1'b1;
        dt_i    = W'(dt);
        e.dt    = dt;
        e.root  = isqrt(dt);
        e.rem   = dt - e.root * e.root;
        e.cyc   = cyc + N + 1 + len;
        sb.push_back(e);
        for (int k = 0; k < N + len; k++) begin
            @(negedge clk);
            chk("busy_calc", busy_o, 1);
            enb_i   = !(len > 0 && k >= sa && k < sa + len);
            start_i = inject && (k == 2);
            dt_i    = (inject && k == 2) ? W'(9) : W'($urandom);
        end
        @(negedge clk);
        enb_i   = 1'b1;
        start_i = 1'b0;
        if (ds > 0) begin
            enb_i = 1'b0;
            for (int k = 0; k < ds; k++) begin
                @(negedge clk);
                chk("valid_hold_done", valid_o, 1);
            end
            enb_i = 1'b1;
        end
        @(negedge clk);
        chk("idle_after_done", busy_o, 0);
    endtask

    task automatic reset_abort(input int unsigned dt);
        wait_idle();
        start_i = 1'b1;
        dt_i    = W'(dt);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 4) rst_i = 1'b1;
        end
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_root", root_o, 0);
        chk("abort_rem", rem_o, 0);
        $display("abort dt=%0d by reset in cycle c+4", dt);
    endtask

    // Monitor: compares each new valid_o pulse against the scoreboard head.
    initial begin : monitor
        logic         vprev;
        logic [N-1:0] rprev;
        logic [N:0]   mprev;
        logic [63:0]  r64;
        exp_t         e;
        vprev = 1'b0;
        rprev = '0;
        mprev = '0;
        forever begin
            @(negedge clk);
            if (valid_o && !vprev) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: root=%0d rem=%0d, expected no result", root_o, rem_o);
                end else begin
                    e   = sb.pop_front();
                    r64 = 64'(root_o);
                    $display("result dt=%0d root=%0d rem=%0d cycle=%0d", e.dt, root_o, rem_o, cyc);
                    chk("root", root_o, e.root);
                    chk("rem", rem_o, e.rem);
                    chk("latency_cycle", cyc, e.cyc);
                    chk("identity", r64 * r64 + 64'(rem_o), e.dt);
                    chk("rem_bound", 64'(rem_o) <= 2 * r64, 1);
                end
            end
            if (valid_o) chk("valid_implies_busy", busy_o, 1);
            if (!rst_edge && !(valid_o && !vprev))
                chk("outputs_hold", {root_o, rem_o}, {rprev, mprev});
            vprev = valid_o;
            rprev = root_o;
            mprev = rem_o;
        end
    end

    initial begin : driver
        int sa, len, ds;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_root", root_o, 0);
        chk("rst_rem", rem_o, 0);
        rst_i = 1'b0;
        do_op(144, 0, 0, 1'b0, 0);
        do_op(0, 0, 0, 1'b0, 0);
        do_op(65535, 0, 0, 1'b0, 0);
        do_op(255, 0, 0, 1'b0, 0);
        do_op(1000, 3, 3, 1'b0, 0);
        do_op(100, 0, 0, 1'b1, 0);
        do_op(50000, 0, 0, 1'b0, 3);
        reset_abort(12345);
        do_op(4095, 0, 0, 1'b0, 0);
        do_op(1, N - 1, 2, 1'b0, 0);
        for (int i = 0; i < 2000; i++) begin
            sa  = int'($urandom_range(0, N - 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            ds  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_op($urandom_range(0, 65535), sa, len, $urandom_range(0, 4) == 0, ds);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrt_seq.md
SQRT_SEQ -- requirements
Module: sqrt_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the radicand width; legal values are even and at least 4.
REQ-002 The block SHALL define the derived constant N = WIDTH/2, the root width and the iteration count.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 enb_i  input  1  clock-enable; when low, all internal state and outputs SHALL hold (replaces any gated clock).
REQ-006 start_i  input  1  request to start a computation on dt_i.
REQ-007 dt_i  input  WIDTH  unsigned radicand, sampled only on an accepted start.
REQ-008 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-009 valid_o  output  1  one-cycle pulse marking root_o/rem_o as the new result.
REQ-010 root_o  output  N  unsigned floor(sqrt(dt)).
REQ-011 rem_o  output  N+1  unsigned dt - root_o^2.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 Start acceptance SHALL occur at a rising edge where state=IDLE, enb_i=1 and start_i=1.
REQ-014 On start acceptance, dt_i SHALL be latched into a shift register, rem and root SHALL be cleared, the iteration counter SHALL be loaded with N-1, and the FSM SHALL go to CALC.
REQ-015 start_i SHALL be ignored in CALC and DONE; no queueing and no effect on the result in progress.
REQ-016 CALC SHALL perform one restoring digit step per enabled edge: rem' = (rem<<2) | top 2 bits of the shift register; trial = (root<<2)|1; the shift register shifts left by 2.
REQ-017 In each CALC step, if rem' >= trial then rem = rem' - trial and root = (root<<1)|1; otherwise rem = rem' and root = root<<1.
REQ-018 The internal rem/trial datapath SHALL be N+2 bits wide with no truncation; the final rem SHALL fit in N+1 bits.
REQ-019 In CALC the counter SHALL decrement each enabled edge; the step taken with counter=0 SHALL move the FSM to DONE and copy root/rem into root_o/rem_o.
REQ-020 In DONE, valid_o=1 for that single cycle; the next enabled edge SHALL move the FSM to IDLE.
REQ-021 If enb_i is held low in DONE, valid_o SHALL stay high until an enabled edge leaves DONE.
REQ-022 valid_o SHALL be 0 in IDLE and CALC.
REQ-023 Latency: with enb_i=1 throughout, a start accepted at the end of cycle c SHALL produce valid_o=1 in cycle c+N+1 (c+9 for WIDTH=16).
REQ-024 Throughput: the earliest next acceptance SHALL be at the end of cycle c+N+2.
REQ-025 root_o and rem_o SHALL hold their last result until the next DONE; they SHALL NOT change during CALC.
REQ-026 Every result SHALL satisfy root_o^2 + rem_o = dt and rem_o <= 2*root_o.
REQ-027 enb_i low at any edge SHALL freeze state, counter, datapath and outputs; computation SHALL resume unchanged when enb_i returns high, with latency extended by the stalled cycles.

Reset
REQ-028 rst_i=1 at a rising edge SHALL force state=IDLE, counter=0, datapath registers=0, root_o=0, rem_o=0, valid_o=0 and busy_o=0.
REQ-029 Reset SHALL take priority over enb_i and start_i.
REQ-030 Reset mid-CALC or in DONE SHALL abort the computation with no valid_o pulse.
REQ-031 The first acceptance after reset SHALL be possible at the first edge after rst_i falls.

Verification
REQ-032 WIDTH=16, start with dt=144 -> valid_o in cycle c+9, root_o=12, rem_o=0, busy_o high in cycles c+1..c+9.
REQ-033 WIDTH=16, dt=0 -> root_o=0, rem_o=0; dt=65535 -> root_o=255, rem_o=510; WIDTH=8, dt=255 -> root_o=15, rem_o=30.
REQ-034 WIDTH=16, dt=1000, with enb_i low for 3 cycles mid-CALC -> valid_o in cycle c+12, root_o=31, rem_o=39, outputs frozen during the stall.
REQ-035 start_i pulsed with dt=9 during CALC of dt=100 -> single result root_o=10, rem_o=0; the second request is dropped.
REQ-036 rst_i asserted in cycle c+4 of a computation -> no valid_o, all outputs 0, busy_o=0 the next cycle, and a new start then completes normally.
REQ-037 A random sweep of all 2^WIDTH radicands for WIDTH=8 and 10^5 random radicands for WIDTH=16 SHALL check REQ-026 and REQ-023.
